// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, waits for the response,
// and aligns/extends load data for MEM/WB, holding it while the pipe is frozen.
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            advance_i,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_address,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic [3:0]      rmask_o,
    output logic            stall_o,
    output logic            misaligned_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_r, next_state_s;
    logic [XLEN-1:0] held_r;
    logic            op_s, is_read_s, is_write_s, bad_s, req_ok_s;
    logic            req_s, stall_s, hold_load_s;
    logic [3:0]      lane_s;
    logic [XLEN-1:0] aligned_s, result_s;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = d >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_align = {{24{b[7]}}, b};
            3'b100:  load_align = {24'h000000, b};
            3'b001:  load_align = {{16{h[15]}}, h};
            3'b101:  load_align = {16'h0000, h};
            3'b010:  load_align = d;
            default: load_align = 32'h00000000;
        endcase
    endfunction

    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: access_bad = 1'b0;
            3'b001, 3'b101: access_bad = off[0];
            3'b010:         access_bad = (off != 2'b00);
            default:        access_bad = 1'b1;
        endcase
    endfunction

    // A simultaneous read+write request is treated as a read.
    assign op_s       = valid_i & (mem_read_i | mem_write_i);
    assign is_read_s  = mem_read_i;
    assign is_write_s = mem_write_i & ~mem_read_i;
    assign bad_s      = access_bad(funct3_i, addr_i[1:0]);
    assign req_ok_s   = rst & op_s & ~bad_s;
    assign lane_s     = lane_mask(funct3_i, addr_i[1:0]);
    assign aligned_s  = is_read_s ? load_align(funct3_i, addr_i[1:0], dmem_rdata) : 32'h00000000;

    // Next-state, request, stall and result selection.
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        hold_load_s  = 1'b0;
        result_s     = 32'h00000000;
        case (state_r)
            IDLE, ACCESS: begin
                if (req_ok_s) begin
                    req_s = 1'b1;
                    if (dmem_resp) begin
                        result_s = aligned_s;
                        if (advance_i) begin
                            next_state_s = IDLE;
                        end else begin
                            next_state_s = HOLD;
                            hold_load_s  = 1'b1;
                        end
                    end else begin
                        stall_s      = 1'b1;
                        next_state_s = ACCESS;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            HOLD: begin
                result_s = held_r;
                if (advance_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and held load result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            held_r  <= 32'h00000000;
        end else begin
            state_r <= next_state_s;
            if (hold_load_s) begin
                held_r <= aligned_s;
            end
        end
    end

    assign dmem_read    = req_s & is_read_s;
    assign dmem_write   = req_s & is_write_s;
    assign dmem_address = {addr_i[XLEN-1:2], 2'b00};
    assign dmem_wmask   = dmem_write ? lane_s : 4'b0000;
    assign dmem_wdata   = store_data(funct3_i, rs2_i);
    assign mem_rdata_o  = result_s;
    assign rmask_o      = (req_ok_s & is_read_s) ? lane_s : 4'b0000;
    assign stall_o      = stall_s;
    assign misaligned_o = rst & op_s & bad_s;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage; sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives the data-memory port: request, word address, byte mask and aligned store data.
- Waits for the memory response, then aligns and sign/zero-extends load data for the MEM/WB register.
- Raises a stall while a data access is outstanding; holds returned data if the pipeline cannot advance.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-low reset.
- valid_i  in  1  a real instruction occupies the MEM stage this cycle (0 = bubble).
- mem_read_i  in  1  instruction is a load.
- mem_write_i  in  1  instruction is a store.
- funct3_i  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  byte address from the ALU.
- rs2_i  in  32  store source data.
- advance_i  in  1  hazard unit loads MEM/WB at the end of this cycle.
- dmem_read  out  1  memory read request.
- dmem_write  out  1  memory write request.
- dmem_address  out  32  {addr_i[31:2],2'b00}.
- dmem_wmask  out  4  byte enables for a write.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_rdata  in  32  read data; valid only with dmem_resp.
- dmem_resp  in  1  one-cycle completion pulse for a read or write.
- mem_rdata_o  out  32  aligned, extended load result for MEM/WB.
- rmask_o  out  4  byte lanes read (for rvfi); 0 when not a load.
- stall_o  out  1  MEM access outstanding; hazard unit freezes all upstream registers and deasserts advance_i.
- misaligned_o  out  1  current access is misaligned or has an illegal funct3; no request is issued.

Behaviour:
Access classification:
- op = valid_i & (mem_read_i | mem_write_i).
- If mem_read_i and mem_write_i are both high, treat as a read.
- misaligned_o is high when op is set and any of:
  - W with addr_i[1:0] != 0
  - H or HU with addr_i[0] = 1
  - funct3 in {011, 110, 111}
- A misaligned op issues no request, stall_o = 0, mem_rdata_o = 0, rmask_o = 0.

Masks and store data, with off = addr_i[1:0]:
- B: mask 0001 << off, wdata = {4{rs2_i[7:0]}}.
- H: mask 0011 << off, wdata = {2{rs2_i[15:0]}}.
- W: mask 1111, wdata = rs2_i.
- dmem_wmask is 0 unless dmem_write = 1.
- rmask_o uses the same lane rule on loads.

Load result, taken from the selected byte/half of dmem_rdata (or of the held register):
- B sign-extends; BU zero-extends.
- H sign-extends; HU zero-extends.
- W passes through unchanged.

FSM states: IDLE, ACCESS, HOLD. Reset: state = IDLE, held data = 0.
- While rst = 0, dmem_read, dmem_write, stall_o and misaligned_o are forced to 0.

IDLE:
- If op and not misaligned: assert the request combinationally this cycle.
  - If dmem_resp = 1 the same cycle: stall_o = 0 and the result is combinational from dmem_rdata.
    - advance_i = 1: stay in IDLE.
    - advance_i = 0: go to HOLD and latch the aligned result.
  - If dmem_resp = 0: stall_o = 1, go to ACCESS.
- Otherwise: no request, stall_o = 0.

ACCESS:
- Request stays asserted with address, mask and data stable; stall_o = 1 until dmem_resp.
- On dmem_resp: stall_o = 0 and the result is combinational from dmem_rdata.
  - advance_i = 1: go to IDLE.
  - advance_i = 0: go to HOLD and latch the aligned result.

HOLD:
- Requests deasserted; the instruction is never re-issued.
- stall_o = 0; mem_rdata_o = held register.
- Go to IDLE when advance_i = 1.

Latency and ordering:
- Latency from request to result is one cycle plus memory wait cycles; 0 extra cycles on a same-cycle response.
- A store completes on dmem_resp; no store data is buffered.
- dmem_resp while no request is outstanding is ignored.

Reset and hold rules:
- Reset mid-ACCESS abandons the request; the next cycle starts in IDLE with no request.
- Inputs are held stable by upstream while stall_o = 1; the block does not sample them into registers, except load data into the HOLD register.

Test Plan:
- LW addr 0x100, dmem_rdata 0xDEADBEEF, resp after 3 cycles, advance_i = !stall_o -> dmem_read held 4 cycles, stall_o high 3 cycles, mem_rdata_o = 0xDEADBEEF on the resp cycle, rmask_o = 1111.
- LB addr 0x103, rdata 0x80FF1234; then LBU same address; then LH addr 0x102 -> 0xFFFFFF80, 0x00000080, 0xFFFF80FF.
- SB addr 0x101, rs2 0x000000AB; SH addr 0x102, rs2 0x1234 -> wmask 0010 / wdata 0xABABABAB; wmask 1100 / wdata 0x12341234; dmem_address 0x100 for both.
- LW addr 0x102; SH addr 0x101 -> misaligned_o = 1, no dmem_read/dmem_write, stall_o = 0, mem_rdata_o = 0.
- LHU addr 0x200, resp with rdata 0x0000ABCD while advance_i = 0 for 2 more cycles -> FSM enters HOLD, no second request, mem_rdata_o = 0x0000ABCD held until advance_i = 1, then IDLE.
- rst driven low during ACCESS -> requests drop in that cycle, state IDLE; a late dmem_resp after reset is ignored; stall_o = 0.
